seq_div: RTL and testbench

Iterative signed divider: the inverse companion to the combinational Booth multiplier `mul`, sharing its two's-complement operand convention and `WIDTH` parameter. It accepts a dividend/divisor pair over a valid/ready handshake and computes one quotient bit per clock with a restoring shift-subtract loop on operand magnitudes. It returns the quotient and remainder over a second valid/ready handshake. It sits beside `mul` in the arithmetic datapath wherever the inverse operation is needed, with area favoured over throughput.

---
 rtl/div_pkg.sv | 24 ++
 rtl/div_step.sv | 32 +++
 rtl/seq_div.sv | 119 +++++++++++
 tb/tb_seq_div.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and two's-complement helpers for the iterative signed divider.
package div_pkg;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Helpers work on a wide carrier and are masked to the caller's width.
  localparam int MAX_W = 64;

  function automatic logic [MAX_W-1:0] width_mask(input int w);
    return (w >= MAX_W) ? '1 : ((MAX_W'(1) << w) - MAX_W'(1));
  endfunction

  function automatic logic [MAX_W-1:0] neg(input logic [MAX_W-1:0] v, input int w);
    return (~v + MAX_W'(1)) & width_mask(w);
  endfunction

  // Unsigned magnitude, so the most negative value maps exactly to 2^(w-1).
  function automatic logic [MAX_W-1:0] abs_u(input logic [MAX_W-1:0] v, input int w);
    logic sign;
    sign = ((v >> (w - 1)) & MAX_W'(1)) != '0;
    return sign ? neg(v, w) : (v & width_mask(w));
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes.
module div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   pr,
  input  logic [WIDTH-1:0] qr,
  input  logic [WIDTH-1:0] dr,
  output logic [WIDTH:0]   pr_next,
  output logic [WIDTH-1:0] qr_next
);

  logic [WIDTH:0]   shifted_pr;
  logic [WIDTH-1:0] shifted_qr;
  logic [WIDTH:0]   trial;

  // pr < dr <= 2^(WIDTH-1) keeps the trial within WIDTH+1 signed bits.
  assign shifted_pr = {pr[WIDTH-1:0], qr[WIDTH-1]};
  assign shifted_qr = {qr[WIDTH-2:0], 1'b0};
  assign trial      = shifted_pr - {1'b0, dr};

  always_comb begin
    // NOTE: every combinational output gets a value on every path, so no latch is inferred.
    if (!trial[WIDTH]) begin
      pr_next = trial;
      qr_next = shifted_qr | WIDTH'(1);
    end else begin
      pr_next = shifted_pr;
      qr_next = shifted_qr;
    end
  end

endmodule

// File: rtl/seq_div.sv
// Iterative signed divider: one quotient bit per clock, valid/ready on both sides.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   pr, pr_step;
  logic [WIDTH-1:0] qr, qr_step, dr, dvd_hold;
  logic             q_sign, r_sign, dbz;
  logic             accept, handoff;

  assign accept  = in_valid && in_ready;
  assign handoff = out_valid && out_ready;

  div_step #(.WIDTH(WIDTH)) u_step (
    .pr      (pr),
    .qr      (qr),
    .dr      (dr),
    .pr_next (pr_step),
    .qr_next (qr_step)
  );

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = CALC;
      CALC:    if (cnt == '0) state_next = FIX;
      FIX:     state_next = DONE;
      DONE:    if (handoff) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state == IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt         <= '0;
      pr          <= '0;
      qr          <= '0;
      dr          <= '0;
      dvd_hold    <= '0;
      q_sign      <= 1'b0;
      r_sign      <= 1'b0;
      dbz         <= 1'b0;
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            qr       <= WIDTH'(abs_u(MAX_W'(dividend), WIDTH));
            dr       <= WIDTH'(abs_u(MAX_W'(divisor), WIDTH));
            dvd_hold <= dividend;
            q_sign   <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
            r_sign   <= dividend[WIDTH-1];
            dbz      <= (divisor == '0);
            pr       <= '0;
            cnt      <= CW'(WIDTH - 1);
          end
        end
        CALC: begin
          pr  <= pr_step;
          qr  <= qr_step;
          cnt <= cnt - 1'b1;
        end
        FIX: begin
          if (dbz) begin
            quotient    <= '1;
            remainder   <= dvd_hold;
            div_by_zero <= 1'b1;
          end else begin
            quotient    <= q_sign ? WIDTH'(neg(MAX_W'(qr), WIDTH)) : qr;
            remainder   <= r_sign ? WIDTH'(neg(MAX_W'(pr[WIDTH-1:0]), WIDTH)) : pr[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
          // Result registers settle on entry to DONE; out_valid follows one edge later.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid   <= 1'b0;
            div_by_zero <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// Self-checking bench for seq_div at WIDTH=8: directed table, corner sequences, random vs model.
module tb_seq_div;

  logic       clk, rst, in_valid, in_ready, out_valid, out_ready, div_by_zero;
  logic [7:0] dividend, divisor, quotient, remainder;

  int n_checks = 0;
  int n_fail   = 0;

  seq_div #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       z;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain integer division truncates toward zero, % follows the dividend's sign.
  function automatic void ref_div(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r, output logic z);
    int sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sb == 0) begin
      q = 8'hFF;
      r = a;
      z = 1'b1;
    end else begin
      q = 8'(sa / sb);
      r = 8'(sa % sb);
      z = 1'b0;
    end
  endfunction

  // Drives one operand pair, returns the result and the edge count from acceptance to out_valid.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       output logic [7:0] q, output logic [7:0] r, output logic z, output int lat);
    int g;
    g = 0;
    @(negedge clk);
    while (!in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  initial begin
    logic [7:0] q, r, eq, er, hold_q, hold_r;
    logic       z, ez, stable, rdy_low, seen;
    int         lat, g;

    vecs[0] = '{8'd100, 8'd7,  8'h0E, 8'h02, 1'b0};
    vecs[1] = '{8'h9C,  8'd7,  8'hF2, 8'hFE, 1'b0};
    vecs[2] = '{8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0};
    vecs[3] = '{8'h9C,  8'hF9, 8'h0E, 8'hFE, 1'b0};
    vecs[4] = '{8'h80,  8'hFF, 8'h80, 8'h00, 1'b0};
    vecs[5] = '{8'h80,  8'h01, 8'h80, 8'h00, 1'b0};
    vecs[6] = '{8'h00,  8'h05, 8'h00, 8'h00, 1'b0};
    vecs[7] = '{8'h05,  8'h00, 8'hFF, 8'h05, 1'b1};
    vecs[8] = '{8'h09,  8'h03, 8'h03, 8'h00, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_quotient", 32'(quotient), 32'd0);
    check("reset_remainder", 32'(remainder), 32'd0);
    check("reset_dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].a, vecs[i].b, q, r, z, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd10);
      check($sformatf("vec%0d_quotient", i), 32'(q), 32'(vecs[i].q));
      check($sformatf("vec%0d_remainder", i), 32'(r), 32'(vecs[i].r));
      check($sformatf("vec%0d_dbz", i), 32'(z), 32'(vecs[i].z));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ready_after", i), 32'(in_ready), 32'd1);
      check($sformatf("vec%0d_dbz_cleared", i), 32'(div_by_zero), 32'd0);
    end

    // Backpressure with a stray operand pulse during CALC.
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd3;
    divisor  = 8'd1;
    @(negedge clk);
    in_valid = 1'b0;
    g = 0;
    while (!out_valid && g < 40) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("bp_out_valid", 32'(out_valid), 32'd1);
    check("bp_quotient", 32'(quotient), 32'h0E);
    check("bp_remainder", 32'(remainder), 32'h02);
    hold_q  = quotient;
    hold_r  = remainder;
    stable  = 1'b1;
    rdy_low = 1'b1;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!out_valid || quotient !== hold_q || remainder !== hold_r) stable = 1'b0;
      if (in_ready !== 1'b0) rdy_low = 1'b0;
    end
    check("bp_outputs_stable", 32'(stable), 32'd1);
    check("bp_in_ready_low", 32'(rdy_low), 32'd1);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_ready", 32'(in_ready), 32'd1);
    check("bp_release_valid", 32'(out_valid), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    check("bp_no_phantom_op", 32'({in_ready, out_valid}), 32'b10);

    // Reset during the 4th CALC cycle of 100 / 7.
    @(negedge clk);
    in_valid = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_quotient", 32'(quotient), 32'd0);
    check("midrst_remainder", 32'(remainder), 32'd0);
    check("midrst_dbz", 32'(div_by_zero), 32'd0);
    seen = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (15) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    do_op(8'd50, 8'd6, q, r, z, lat);
    check("post_rst_latency", 32'(lat), 32'd10);
    check("post_rst_quotient", 32'(q), 32'd8);
    check("post_rst_remainder", 32'(r), 32'd2);

    // Random operands against the arithmetic model.
    for (int i = 0; i < 60; i++) begin
      logic [7:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
      if (i == 0) ra = 8'h80;
      if (i == 1) rb = 8'h80;
      ref_div(ra, rb, eq, er, ez);
      do_op(ra, rb, q, r, z, lat);
      check($sformatf("rnd%0d_%0h_%0h_latency", i, ra, rb), 32'(lat), 32'd10);
      check($sformatf("rnd%0d_%0h_%0h_quotient", i, ra, rb), 32'(q), 32'(eq));
      check($sformatf("rnd%0d_%0h_%0h_remainder", i, ra, rb), 32'(r), 32'(er));
      check($sformatf("rnd%0d_%0h_%0h_dbz", i, ra, rb), 32'(z), 32'(ez));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
